// File: rtl/vlut_rev_search_if.sv
// Bus for the reverse-lookup table: search handshake, table write port and
// forward-read port.
interface vlut_rev_search_if #(
  parameter int W  = 8,
  parameter int RW = 3
);
  logic          start;
  logic [W-1:0]  target;
  logic          wren;
  logic [RW-1:0] wrrow;
  logic [W-1:0]  wrvalue;
  logic [RW-1:0] rdrow;
  logic [W-1:0]  rdvalue;
  logic          busy;
  logic          done;
  logic          hit;
  logic [RW-1:0] row;

  modport master (
    output start, target, wren, wrrow, wrvalue, rdrow,
    input  rdvalue, busy, done, hit, row
  );

  modport slave (
    input  start, target, wren, wrrow, wrvalue, rdrow,
    output rdvalue, busy, done, hit, row
  );
endinterface

// File: rtl/vlut_rev_search.sv
// Small register table with forward read and a sequential reverse search
// that returns the lowest row holding the requested value.
module vlut_rev_search #(
  parameter int ROWS = 8,
  parameter int W    = 8,
  parameter int RW   = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               reset,
  vlut_rev_search_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_r;
  logic [RW-1:0]  idx_r;
  logic [W-1:0]   target_r;
  logic           hit_r;
  logic [RW-1:0]  row_r;
  logic [W-1:0]   table_r [ROWS];
  logic           match_s;

  // Power-up contents of the table; rows beyond the seeded ones are zero.
  function automatic logic [W-1:0] reset_value(input int r);
    logic [W-1:0] v;
    case (r)
      32'sd0:  v = W'(32'd0);
      32'sd1:  v = W'(32'd1);
      32'sd2:  v = W'(32'd30);
      32'sd3:  v = W'(32'd60);
      default: v = W'(32'd0);
    endcase
    return v;
  endfunction

  // Table storage: reset seeds the contents, otherwise the write port updates one row.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ROWS; i++) begin
        table_r[i] <= reset_value(i);
      end
    end else if (bus.wren) begin
      table_r[bus.wrrow] <= bus.wrvalue;
    end else begin
      table_r[bus.wrrow] <= table_r[bus.wrrow];
    end
  end

  // Compare uses pre-edge table contents, so a same-edge write is not seen.
  always_comb begin
    match_s = 1'b0;
    if (table_r[idx_r] == target_r) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  // Search controller: one row per cycle, first match wins, idx never wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      idx_r    <= {RW{1'b0}};
      target_r <= {W{1'b0}};
      hit_r    <= 1'b0;
      row_r    <= {RW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            target_r <= bus.target;
            idx_r    <= {RW{1'b0}};
            state_r  <= ST_SCAN;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (match_s) begin
            row_r   <= idx_r;
            hit_r   <= 1'b1;
            state_r <= ST_DONE;
          end else if (idx_r == RW'(ROWS - 1)) begin
            row_r   <= {RW{1'b0}};
            hit_r   <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            idx_r   <= idx_r + RW'(1);
            state_r <= ST_SCAN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rdvalue = table_r[bus.rdrow];
  assign bus.busy    = (state_r == ST_SCAN);
  assign bus.done    = (state_r == ST_DONE);
  assign bus.hit     = hit_r;
  assign bus.row     = row_r;

endmodule

// File: tb/tb_vlut_rev_search.sv
// Self-checking bench for vlut_rev_search: directed scenarios plus randomized
// searches against a timeline model of the table.
module tb_vlut_rev_search;
  localparam int ROWS = 8;
  localparam int W    = 8;
  localparam int RW   = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   mtbl [ROWS];

  vlut_rev_search_if #(.W(W), .RW(RW)) bus ();

  vlut_rev_search #(.ROWS(ROWS), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    for (int i = 0; i < ROWS; i++) mtbl[i] = 0;
    mtbl[1] = 1;
    mtbl[2] = 30;
    mtbl[3] = 60;
  endtask

  task automatic sweep;
    for (int i = 0; i < ROWS; i++) begin
      bus.rdrow = RW'(i);
      #1;
      chk("rdvalue", 32'(bus.rdvalue), 32'(mtbl[i]));
    end
  endtask

  task automatic wr(input int r, input int v);
    bus.wren    = 1'b1;
    bus.wrrow   = RW'(r);
    bus.wrvalue = W'(v);
    tick();
    bus.wren    = 1'b0;
    mtbl[r]     = v;
  endtask

  // Edge 0 accepts start; row i is compared at edge i+1. A write landing at
  // edge w is visible only to comparisons made at later edges.
  task automatic search(input int t, input int wr_at, input int wr_row,
                        input int wr_val, input bit pulses);
    int exp_row, exp_hit, exp_lat, lat, bcnt, v;
    exp_row = 0; exp_hit = 0; exp_lat = ROWS;
    for (int i = 0; i < ROWS; i++) begin
      v = (wr_at >= 0 && wr_row == i && i + 1 > wr_at) ? wr_val : mtbl[i];
      if (v == t && exp_hit == 0) begin
        exp_hit = 1; exp_row = i; exp_lat = i + 1;
      end
    end
    if (wr_at >= 0 && wr_at <= exp_lat) mtbl[wr_row] = wr_val;

    bus.start   = 1'b1;
    bus.target  = W'(t);
    bus.wrrow   = RW'(wr_row);
    bus.wrvalue = W'(wr_val);
    bus.wren    = (wr_at == 0);
    tick();
    lat  = -1;
    bcnt = bus.busy ? 1 : 0;
    for (int e = 1; e <= ROWS + 2; e++) begin
      bus.start  = pulses & e[0];
      bus.target = W'($urandom);
      bus.wren   = (wr_at == e);
      tick();
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = e;
        break;
      end
    end
    bus.wren  = 1'b0;
    bus.start = pulses;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("hit", 32'(bus.hit), 32'(exp_hit));
    chk("row", 32'(bus.row), 32'(exp_row));
    chk("busy_cycles", 32'(bcnt), 32'(exp_lat));
    tick();
    bus.start = 1'b0;
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("idle_not_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    chk("no_second_done", 32'(bus.done | bus.busy), 32'd0);
    chk("hit_hold", 32'(bus.hit), 32'(exp_hit));
    chk("row_hold", 32'(bus.row), 32'(exp_row));
  endtask

  function automatic int pick_value();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 30;
      2:       return 60;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int dcnt, t, wa;
    bus.start = 1'b0; bus.target = '0; bus.wren = 1'b0;
    bus.wrrow = '0; bus.wrvalue = '0; bus.rdrow = '0;
    model_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_row", 32'(bus.row), 32'd0);
    sweep();

    search(60, -1, 0, 0, 1'b0);
    search(0, -1, 0, 0, 1'b0);
    search(99, -1, 0, 0, 1'b0);
    search(99, 3, 6, 99, 1'b0);
    wr(6, 0);
    search(99, 7, 6, 99, 1'b0);
    search(99, -1, 0, 0, 1'b1);
    search(123, 0, 5, 123, 1'b1);
    sweep();

    // Abort a scan with reset while idx is 2; reset must win over start/write.
    bus.start = 1'b1; bus.target = W'(8'd99);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b0; bus.start = 1'b1; bus.wren = 1'b1;
    bus.wrrow = RW'(4); bus.wrvalue = W'(8'd55);
    tick();
    reset = 1'b1; bus.start = 1'b0; bus.wren = 1'b0;
    model_reset();
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_hit", 32'(bus.hit), 32'd0);
    chk("abort_row", 32'(bus.row), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) dcnt++;
      tick();
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    sweep();
    search(60, -1, 0, 0, 1'b0);

    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        wr(int'($urandom_range(0, ROWS - 1)), pick_value());
      end
      t  = ($urandom_range(0, 1) == 0) ? mtbl[$urandom_range(0, ROWS - 1)] : pick_value();
      wa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, ROWS)) : -1;
      search(t, wa, int'($urandom_range(0, ROWS - 1)), pick_value(), 1'($urandom_range(0, 1)));
    end
    sweep();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
